// File: rtl/mixcolumn_engine.sv
// mixcolumn_engine: iterative AES MixColumns / InvMixColumns, one 32-bit column per cycle
module mixcolumn_engine #(
    parameter int NB     = 4,
    parameter int INV_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [32*NB-1:0] in_data,
    input  logic            in_inv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*NB-1:0] out_data,
    output logic            busy
);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic             armed, inv, accept, last;
    logic [CW-1:0]    cnt;
    logic [32*NB-1:0] w, w_nxt;
    logic [31:0]      cur, mixed;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd(input logic [31:0] x);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = x;
        return {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
                xt(b1) ^ xt(b2) ^ b2 ^ b3 ^ b0,
                xt(b2) ^ xt(b3) ^ b3 ^ b0 ^ b1,
                xt(b3) ^ xt(b0) ^ b0 ^ b1 ^ b2};
    endfunction

    // Inverse matrix factors as forward matrix times {05,00,04,00} circulant
    function automatic logic [31:0] pre(input logic [31:0] x);
        logic [7:0] b0, b1, b2, b3, u, v;
        {b0, b1, b2, b3} = x;
        u = xt(xt(b0 ^ b2));
        v = xt(xt(b1 ^ b3));
        return {b0 ^ u, b1 ^ v, b2 ^ u, b3 ^ v};
    endfunction

    assign last     = (cnt == CW'(NB - 1));
    assign out_data = w;

    // State register; armed keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= nxt;
            armed <= 1'b1;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        nxt       = state;
        in_ready  = (state == IDLE) && armed;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        accept    = in_ready && in_valid;
        if (accept)
            nxt = RUN;
        else if (state == RUN && last)
            nxt = DONE;
        else if (state == DONE && out_ready)
            nxt = IDLE;
    end

    // Select the current column, transform it and write it back in place
    always_comb begin
        cur = '0;
        for (int c = 0; c < NB; c++)
            cur = (cnt == CW'(c)) ? w[32*(NB-c)-1 -: 32] : cur;
        mixed = fwd((inv && INV_EN != 0) ? pre(cur) : cur);
        w_nxt = w;
        for (int c = 0; c < NB; c++)
            if (cnt == CW'(c)) w_nxt[32*(NB-c)-1 -: 32] = mixed;
    end

    // Working register, column counter and latched mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w   <= '0;
            cnt <= '0;
            inv <= 1'b0;
        end else if (accept) begin
            w   <= in_data;
            cnt <= '0;
            inv <= in_inv && (INV_EN != 0);
        end else if (state == RUN) begin
            w   <= w_nxt;
            cnt <= last ? cnt : cnt + 1'b1;
        end
    end
endmodule

// File: doc/mixcolumn_engine.md
MIXCOLUMN_ENGINE -- requirements
Module: mixcolumn_engine

Interface
REQ-001 The block SHALL have parameter NB, default 4, giving the number of 32-bit columns per state (legal range 1..8).
REQ-002 The block SHALL have parameter INV_EN, default 1, where 1 enables inverse MixColumns and 0 forces forward-only operation.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: in_data/in_inv are presented.
REQ-006 Port in_ready, output, 1 bit: the block accepts a state this cycle.
REQ-007 Port in_data, input, 32*NB bits: input state; column c occupies bits [32*(NB-c)-1 -: 32]; byte 0 of each column is its MSB byte.
REQ-008 Port in_inv, input, 1 bit: 0 = forward MixColumns, 1 = inverse MixColumns.
REQ-009 Port out_valid, output, 1 bit: out_data holds a completed result.
REQ-010 Port out_ready, input, 1 bit: downstream takes the result.
REQ-011 Port out_data, output, 32*NB bits: result state, same layout as in_data.
REQ-012 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 exactly in IDLE; an accept occurs when in_valid and in_ready are both 1.
REQ-015 On accept, the block SHALL latch in_data into a working register, latch the mode as in_inv AND INV_EN, clear the column counter to 0, and go to RUN.
REQ-016 In RUN, the block SHALL transform one column per cycle, in order 0..NB-1, writing the result back in place.
REQ-017 The counter SHALL be wide enough for NB; after column NB-1 the FSM SHALL go to DONE, with no wrap to column 0.
REQ-018 Forward mode SHALL compute per column (b0..b3): r_i = 2*b_i ^ 3*b_(i+1) ^ b_(i+2) ^ b_(i+3), indices mod 4, GF(2^8) modulus 0x11B.
REQ-019 Inverse mode SHALL compute r_i = 0E*b_i ^ 0B*b_(i+1) ^ 0D*b_(i+2) ^ 09*b_(i+3) over the same field.
REQ-020 out_valid SHALL be 1 exactly in DONE, and out_data SHALL equal the working register, stable while out_valid=1 and out_ready=0.
REQ-021 Latency SHALL be fixed: a state accepted at edge T gives out_valid=1 after edge T+NB, independent of data and mode.
REQ-022 In DONE, out_ready=1 SHALL return the FSM to IDLE at the next edge, and in_ready SHALL NOT be asserted in that same cycle.
REQ-023 in_valid, in_data and in_inv changes outside IDLE SHALL be ignored; the latched mode SHALL hold for the whole operation.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 With INV_EN=0, in_inv SHALL be ignored and the inverse multiplier logic need not be synthesised.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, out_valid=0, in_ready=0 (in_ready returns to 1 on the first edge after release), counter=0, working register=0 and out_data=0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the operation with no partial result presented afterward.

Verification
REQ-028 NB=1, forward, column db135345 -> out_data 8e4da1bc, out_valid rises exactly 1 cycle after accept.
REQ-029 NB=4, forward, state d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> 046681e5_e0cb199a_48f8d37a_2806264c after 4 cycles.
REQ-030 NB=4, inverse on the REQ-029 output -> d4bf5d30_e0b452ae_b84111f1_1e2798e5; with INV_EN=0 and in_inv=1 -> forward result instead.
REQ-031 Fixed points: columns c6c6c6c6 and 01010101 are unchanged in both modes; f20a225c forward -> 9fdc589d.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable and in_ready=0 throughout; in_valid pulses during RUN/DONE are not accepted.
REQ-033 Reset mid-RUN (after column 1) -> all outputs 0 at once; the next accepted state produces a correct result with normal latency.
